// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models mult/div latency.
// Optional macro MDU_KILL_EN adds md_kill to squash a flushed E instruction.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        md_valid,
    input  logic [3:0]  md_type,
`ifdef MDU_KILL_EN
    input  logic        md_kill,
`endif
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    logic        kill;
    logic        is_mul;
    logic        is_div;
    logic        sgn;
    logic        mt_wr;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] prod;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] q_abs;
    logic [31:0] r_abs;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [3:0]  cnt;
    logic [31:0] sh_hi;
    logic [31:0] sh_lo;
    logic        sh_wr;

`ifdef MDU_KILL_EN
    assign kill = md_kill;
`else
    assign kill = 1'b0;
`endif

    assign is_mul = (md_type == MD_MULT) || (md_type == MD_MULTU);
    assign is_div = (md_type == MD_DIV) || (md_type == MD_DIVU);
    assign sgn    = (md_type == MD_MULT) || (md_type == MD_DIV);

    assign start = md_valid & (is_mul | is_div) & ~busy & ~kill;
    assign mt_wr = md_valid & ~busy & ~kill &
                   ((md_type == MD_MTHI) || (md_type == MD_MTLO));

    // Sign-extend to 64 bits so one multiplier serves mult and multu.
    assign op_a = {{32{sgn & rs_data[31]}}, rs_data};
    assign op_b = {{32{sgn & rt_data[31]}}, rt_data};
    assign prod = op_a * op_b;

    // Divide magnitudes, then fix signs; avoids signed-overflow corner cases.
    assign a_abs = (sgn && rs_data[31]) ? -rs_data : rs_data;
    assign b_abs = (sgn && rt_data[31]) ? -rt_data : rt_data;
    assign q_abs = a_abs / b_abs;
    assign r_abs = a_abs % b_abs;
    assign quo   = (sgn && (rs_data[31] ^ rt_data[31])) ? -q_abs : q_abs;
    assign rem   = (sgn && rs_data[31]) ? -r_abs : r_abs;

    assign res_hi = is_mul ? prod[63:32] : rem;
    assign res_lo = is_mul ? prod[31:0]  : quo;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_wr <= 1'b0;
        end else begin
            if (start) begin
                sh_hi <= res_hi;
                sh_lo <= res_lo;
                sh_wr <= ~(is_div && (rt_data == '0));
                cnt   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                busy  <= 1'b1;
            end else if (busy) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    busy <= 1'b0;
                    if (sh_wr) begin
                        hi <= sh_hi;
                        lo <= sh_lo;
                    end
                end
            end
            if (mt_wr) begin
                if (md_type == MD_MTHI) hi <= rs_data;
                else                    lo <= rs_data;
            end
        end
    end

    always_comb begin
        md_out = '0;
        unique case (1'b1)
            (md_type == MD_MFHI): md_out = hi;
            (md_type == MD_MFLO): md_out = lo;
            default:              md_out = '0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed plan plus randomized traffic
// against a timestamp-based behavioural model of HI/LO and latency.
module tb_e_mdu;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        md_valid;
    logic [3:0]  md_type;
    logic        md_kill;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .md_valid(md_valid),
        .md_type(md_type),
`ifdef MDU_KILL_EN
        .md_kill(md_kill),
`endif
        .rs_data(rs_data),
        .rt_data(rt_data),
        .start(start),
        .busy(busy),
        .hi(hi),
        .lo(lo),
        .md_out(md_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: cycle index, commit timestamp and pending result.
    longint      now = 0;
    longint      done_at = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] p_hi = 0;
    logic [31:0] p_lo = 0;
    logic        p_wr = 0;

    logic        s_start;
    logic        s_busy;
    logic [31:0] s_mdout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, now);
        end
    endtask

    function automatic logic kill_now();
`ifdef MDU_KILL_EN
        return md_kill;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic is_op(input logic [3:0] t);
        return t >= 4'd1 && t <= 4'd4;
    endfunction

    task automatic compare();
        logic        e_busy;
        logic        e_start;
        logic [31:0] e_out;
        e_busy  = now < done_at;
        e_start = md_valid && is_op(md_type) && !e_busy && !kill_now();
        e_out   = (md_type == 4'd5) ? m_hi : (md_type == 4'd6) ? m_lo : 32'h0;
        chk("start", 32'(start), 32'(e_start));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("md_out", md_out, e_out);
        s_start = start;
        s_busy  = busy;
        s_mdout = md_out;
    endtask

    task automatic model_edge();
        logic   b;
        longint a_s, b_s;
        logic [63:0] pu;
        b = now < done_at;
        if (!reset_n) begin
            m_hi = 0; m_lo = 0; done_at = 0; p_wr = 0;
        end else begin
            if (md_valid && is_op(md_type) && !b && !kill_now()) begin
                p_wr = 1;
                case (md_type)
                    4'd1: begin
                        a_s = longint'($signed(rs_data));
                        b_s = longint'($signed(rt_data));
                        pu = 64'(a_s * b_s);
                    end
                    4'd2: pu = {32'h0, rs_data} * {32'h0, rt_data};
                    4'd3: begin
                        a_s = longint'($signed(rs_data));
                        b_s = longint'($signed(rt_data));
                        if (b_s == 0) begin p_wr = 0; pu = 0; end
                        else pu = {32'(a_s % b_s), 32'(a_s / b_s)};
                    end
                    default: begin
                        a_s = longint'({32'h0, rs_data});
                        b_s = longint'({32'h0, rt_data});
                        if (b_s == 0) begin p_wr = 0; pu = 0; end
                        else pu = {32'(a_s % b_s), 32'(a_s / b_s)};
                    end
                endcase
                p_hi = pu[63:32];
                p_lo = pu[31:0];
                done_at = now + 1 + ((md_type <= 4'd2) ? NM : ND);
            end else if (b && now + 1 == done_at && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
            if (md_valid && !b && !kill_now() && md_type == 4'd7) m_hi = rs_data;
            if (md_valid && !b && !kill_now() && md_type == 4'd8) m_lo = rs_data;
        end
        now++;
    endtask

    task automatic cyc(input logic v, input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] b, input logic r = 1'b1, input logic k = 1'b0);
        md_valid = v; md_type = t; rs_data = a; rt_data = b;
        reset_n = r; md_kill = k;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_op(input string nm, input logic [3:0] t, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] eh, input logic [31:0] el);
        int cnt;
        cnt = 0;
        cyc(1'b1, t, a, b);
        chk({nm, "_start"}, 32'(s_start), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 4'd0, 32'h0, 32'h0);
            if (!s_busy) break;
            cnt++;
        end
        chk({nm, "_busy_len"}, cnt, n);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        md_valid = 0; md_type = 0; rs_data = 0; rt_data = 0;
        md_kill = 0; reset_n = 0;
        #1;
        cyc(1'b0, 4'd0, 0, 0, 1'b0);
        cyc(1'b0, 4'd0, 0, 0, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        run_op("mult", 4'd1, 32'hFFFFFFFF, 32'h2, NM, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'h2, NM, 32'h00000001, 32'hFFFFFFFE);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'h2, ND, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0", 4'd4, 32'h7, 32'h0, ND, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, ND, 32'h0, 32'h80000000);

        cyc(1'b1, 4'd7, 32'h12345678, 32'h0);
        cyc(1'b1, 4'd5, 32'h0, 32'h0);
        chk("mfhi", s_mdout, 32'h12345678);

        cyc(1'b1, 4'd1, 32'h3, 32'h4);
        cyc(1'b1, 4'd1, 32'h5, 32'h6);
        chk("mult_busy_start", 32'(s_start), 32'h0);
        cyc(1'b1, 4'd7, 32'hDEADBEEF, 32'h0);
        repeat (NM) cyc(1'b0, 4'd0, 0, 0);
        chk("mult2_hi", hi, 32'h0);
        chk("mult2_lo", lo, 32'd12);

        cyc(1'b1, 4'd3, 32'd100, 32'd3);
        cyc(1'b0, 4'd0, 0, 0);
        cyc(1'b0, 4'd0, 0, 0);
        cyc(1'b0, 4'd0, 0, 0, 1'b0);
        cyc(1'b0, 4'd0, 0, 0);
        chk("rstmid_busy", 32'(s_busy), 32'h0);
        chk("rstmid_hi", hi, 32'h0);
        chk("rstmid_lo", lo, 32'h0);
        repeat (ND + 3) cyc(1'b0, 4'd0, 0, 0);
        chk("rstmid_late_lo", lo, 32'h0);

`ifdef MDU_KILL_EN
        cyc(1'b1, 4'd1, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b1);
        chk("kill_start", 32'(s_start), 32'h0);
        cyc(1'b0, 4'd0, 0, 0);
        chk("kill_busy", 32'(s_busy), 32'h0);
        chk("kill_lo", lo, 32'h0);
        run_op("nokill", 4'd1, 32'hFFFFFFFF, 32'h2, NM, 32'hFFFFFFFF, 32'hFFFFFFFE);
`endif

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 9) != 0,
                4'($urandom_range(0, 15)),
                pick(), pick(),
                $urandom_range(0, 299) != 0,
                $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Execute-stage multiply/divide unit that consumes the 4-bit MDType field from the centralized decoder, carried down the pipeline to E.
- Owns the architectural HI/LO registers.
- Models multi-cycle mult/div latency with a busy counter.
- Supplies mfhi/mflo read data to the E-stage result mux.
- The hazard unit stalls D on any MD-type instruction while start or busy is high.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
md_valid  in  1  E-stage slot holds a real instruction (0 = bubble)
md_type  in  4  MDType: none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8; values 9..15 behave as none
rs_data  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
rt_data  in  32  forwarded rt operand (divisor / multiplier)
start  out  1  combinational; a mult/div is accepted this cycle
busy  out  1  registered; an operation is in flight
hi  out  32  architectural HI register
lo  out  32  architectural LO register
md_out  out  32  combinational; hi when md_type=mfhi, lo when md_type=mflo, else 0

Behaviour:
- Reset (reset_n=0 at posedge): hi=0, lo=0, busy=0, counter=0, pending result discarded. Applies even mid-operation.
- start = md_valid & md_type in {1..4} & ~busy.
- On start edge:
  - Compute the 64-bit result into shadow registers.
  - counter <= MULT_CYCLES or DIV_CYCLES.
  - busy <= 1.
- While busy:
  - counter decrements each cycle.
  - On the edge where counter goes 1 -> 0: hi/lo <= shadow, busy <= 0, same edge.
- Net effect: busy is high exactly N cycles after the start cycle. The new HI/LO values are visible the cycle busy first reads 0.
- mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0]. multu: same, unsigned.
- div: lo = signed quotient, truncated toward zero; hi = remainder, sign of dividend. divu: unsigned.
- div/divu with rt_data=0:
  - Busy for DIV_CYCLES as normal.
  - hi/lo left unchanged at commit.
- div of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo with md_valid & ~busy: hi (or lo) <= rs_data at next edge. No busy.
- md_type in {1..4} or {7,8} while busy:
  - Ignored; the hazard unit guarantees this never happens.
  - No error flag; the in-flight result commits normally.
- mfhi/mflo: md_out combinational from the current hi/lo. Has no effect on state.
- md_valid=0: no state change regardless of md_type.

Optional Feature:
Macro MDU_KILL_EN.
- Defined:
  - Adds input md_kill (1 bit), asserted by exception logic when the E instruction is being flushed.
  - md_kill=1 gates start and mthi/mtlo writes that cycle.
  - An already in-flight operation still completes and commits.
- Undefined: port absent; behaviour as if md_kill=0.

Test Plan:
- mult with rs=0xFFFFFFFF, rt=0x00000002 -> start=1 for 1 cycle, busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/0 -> busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678, then mfhi next cycle -> md_out=0x12345678. A second mult presented while busy -> start=0 and the first result commits unaltered.
- reset_n=0 on the third busy cycle of a div -> next cycle busy=0, hi=lo=0, and no later commit occurs.
- (MDU_KILL_EN) mult with md_kill=1 -> start=0, busy stays 0, hi/lo unchanged. Repeat with md_kill=0 -> normal 5-cycle operation.
